// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S serializer with a generated bit clock, one-pair holding register.
// Ports:
//   dac_clk      - sole clock, all logic on its rising edge
//   dac_clk_rst  - synchronous active-high reset
//   dataL/dataR  - left/right samples (two's complement), accepted on valid && ready
//   valid/ready  - pair handshake; ready is high while the holding register is empty
//   i2s_bclk     - bit clock, half-period of BCLK_DIV dac_clk cycles
//   i2s_wclk     - word clock, 0 = left slot, 1 = right slot
//   i2s_dout     - serial data, MSB one bclk after the wclk edge
//   frame_start  - one-cycle pulse at every frame load
//   underrun     - one-cycle pulse at a frame load with no pair held
module i2s_tx #(
  parameter int unsigned WIDTH     = 24,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned BCLK_DIV  = 4
) (
  input  logic             dac_clk,
  input  logic             dac_clk_rst,
  input  logic [WIDTH-1:0] dataL,
  input  logic [WIDTH-1:0] dataR,
  input  logic             valid,
  output logic             ready,
  output logic             i2s_bclk,
  output logic             i2s_wclk,
  output logic             i2s_dout,
  output logic             frame_start,
  output logic             underrun
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned DIV_W      = $clog2(BCLK_DIV);
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
  localparam int unsigned K_W        = $clog2(SLOT_BITS);
  localparam int unsigned IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             bclk_q, bclk_d;
  logic             wclk_q, wclk_d;
  logic             dout_q, dout_d;
  logic             fs_q, fs_d;
  logic             ur_q, ur_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] hold_l_q, hold_l_d;
  logic [WIDTH-1:0] hold_r_q, hold_r_d;
  logic             hold_full_q, hold_full_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] frame_l_q, frame_l_d;
  logic [WIDTH-1:0] frame_r_q, frame_r_d;

  logic             div_wrap;
  logic             fall;
  logic [CNT_W-1:0] bit_n;
  logic             right_slot;
  logic [K_W-1:0]   slot_k;
  logic [WIDTH-1:0] sample;
  logic             accept;

  // Next-state logic for divider, bit counter, holding and frame registers
  always_comb begin
    div_d       = div_q;
    bclk_d      = bclk_q;
    wclk_d      = wclk_q;
    dout_d      = dout_q;
    fs_d        = 1'b0;
    ur_d        = 1'b0;
    bit_d       = bit_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    hold_full_d = hold_full_q;
    frame_l_d   = frame_l_q;
    frame_r_d   = frame_r_q;

    div_wrap = (div_q == DIV_W'(BCLK_DIV - 1));
    fall     = div_wrap && bclk_q;
    accept   = valid && ready_q;

    if (div_wrap) begin
      div_d  = '0;
      bclk_d = ~bclk_q;
    end else begin
      div_d  = div_q + DIV_W'(1);
    end

    // Bit position that becomes current at the next fall event
    bit_n      = (bit_q == CNT_W'(FRAME_BITS - 1)) ? '0 : bit_q + CNT_W'(1);
    right_slot = (bit_n >= CNT_W'(SLOT_BITS));
    slot_k     = right_slot ? K_W'(bit_n - CNT_W'(SLOT_BITS)) : K_W'(bit_n);
    sample     = right_slot ? frame_r_q : frame_l_q;

    if (accept) begin
      hold_l_d    = dataL;
      hold_r_d    = dataR;
      hold_full_d = 1'b1;
    end

    if (fall) begin
      bit_d  = bit_n;
      wclk_d = right_slot;
      // Slot bit 0 is the one-bclk Philips delay; bits past WIDTH pad with zeros
      if ((slot_k != '0) && (slot_k <= K_W'(WIDTH))) begin
        dout_d = sample[IDX_W'(K_W'(WIDTH) - slot_k)];
      end else begin
        dout_d = 1'b0;
      end
      // Frame load: ready is low whenever hold_full is set, so accept cannot collide here
      if (bit_n == '0) begin
        fs_d = 1'b1;
        if (hold_full_q) begin
          frame_l_d   = hold_l_q;
          frame_r_d   = hold_r_q;
          hold_full_d = 1'b0;
        end else begin
          frame_l_d = '0;
          frame_r_d = '0;
          ur_d      = 1'b1;
        end
      end
    end

    // Registered mirror of the next holding state so a held-high valid is taken once
    ready_d = ~hold_full_d;
  end

  // State registers with synchronous reset
  always_ff @(posedge dac_clk) begin
    if (dac_clk_rst) begin
      div_q       <= '0;
      bclk_q      <= 1'b0;
      wclk_q      <= 1'b0;
      dout_q      <= 1'b0;
      fs_q        <= 1'b0;
      ur_q        <= 1'b0;
      bit_q       <= CNT_W'(FRAME_BITS - 1);
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      hold_full_q <= 1'b0;
      ready_q     <= 1'b1;
      frame_l_q   <= '0;
      frame_r_q   <= '0;
    end else begin
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      wclk_q      <= wclk_d;
      dout_q      <= dout_d;
      fs_q        <= fs_d;
      ur_q        <= ur_d;
      bit_q       <= bit_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      hold_full_q <= hold_full_d;
      ready_q     <= ready_d;
      frame_l_q   <= frame_l_d;
      frame_r_q   <= frame_r_d;
    end
  end

  assign ready       = ready_q;
  assign i2s_bclk    = bclk_q;
  assign i2s_wclk    = wclk_q;
  assign i2s_dout    = dout_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;

endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed bench for i2s_tx with default parameters (bclk period 8, frame 512 cycles).
module tb_i2s_tx;

  localparam int unsigned WIDTH     = 24;
  localparam int unsigned SLOT_BITS = 32;
  localparam int unsigned BCLK_DIV  = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             valid = 1'b0;
  logic [WIDTH-1:0] dl = '0;
  logic [WIDTH-1:0] dr = '0;
  logic             ready, bclk, wclk, dout, fs, ur;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  i2s_tx #(.WIDTH(WIDTH), .SLOT_BITS(SLOT_BITS), .BCLK_DIV(BCLK_DIV)) dut (
    .dac_clk    (clk),
    .dac_clk_rst(rst),
    .dataL      (dl),
    .dataR      (dr),
    .valid      (valid),
    .ready      (ready),
    .i2s_bclk   (bclk),
    .i2s_wclk   (wclk),
    .i2s_dout   (dout),
    .frame_start(fs),
    .underrun   (ur)
  );

  // Serial outputs may only move on a bclk falling edge (reset cycles excepted)
  logic rst_last = 1'b1;
  logic seen = 1'b0;
  logic p_bclk, p_wclk, p_dout;
  int   viol = 0;
  always @(posedge clk) rst_last <= rst;
  always @(negedge clk) begin
    if (seen && !rst_last) begin
      if (((dout !== p_dout) || (wclk !== p_wclk)) && !(p_bclk && !bclk)) viol++;
    end
    p_bclk = bclk;
    p_wclk = wclk;
    p_dout = dout;
    seen   = !rst_last;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    valid = 1'b0;
    tick();
    tick();
    rst   = 1'b0;
  endtask

  task automatic wait_fs(input string tag, output int elapsed);
    elapsed = 0;
    do begin
      tick();
      elapsed++;
    end while (!fs && elapsed < 600);
    if (!fs) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout got=no frame_start exp=frame_start within 600 cycles", tag);
    end
  endtask

  // Sample dout/wclk at the next 64 bclk rises, MSB of each word = slot bit 0
  task automatic capture(input string tag, output logic [31:0] sl, output logic [31:0] sr,
                         output logic [31:0] wl, output logic [31:0] wr);
    logic prev;
    int   got;
    int   budget;
    sl = '0; sr = '0; wl = '0; wr = '0;
    prev = bclk;
    got = 0;
    budget = 0;
    while (got < 64 && budget < 64 * 2 * BCLK_DIV + 16) begin
      tick();
      budget++;
      if (!prev && bclk) begin
        if (got < 32) begin
          sl[5'(31 - got)] = dout;
          wl[5'(31 - got)] = wclk;
        end else begin
          sr[5'(63 - got)] = dout;
          wr[5'(63 - got)] = wclk;
        end
        got++;
      end
      prev = bclk;
    end
    if (got < 64) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_rises got=%0d exp=64", tag, got);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sl, sr, wl, wr;
    int el;
    int fs_cnt, ur_cnt, ones, fs_last;

    // Reset values
    do_reset();
    rst = 1'b1;
    tick();
    chk("rst_bclk",  32'(bclk),  32'd0);
    chk("rst_wclk",  32'(wclk),  32'd0);
    chk("rst_dout",  32'(dout),  32'd0);
    chk("rst_fs",    32'(fs),    32'd0);
    chk("rst_ur",    32'(ur),    32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    rst = 1'b0;

    // Idle after release: bclk timing and periodic underrun frames
    fs_cnt = 0; ur_cnt = 0; ones = 0; fs_last = 0;
    for (int t = 1; t <= 520; t++) begin
      tick();
      if (t == 3) chk("idle_bclk_t3", 32'(bclk), 32'd0);
      if (t == 4) chk("idle_bclk_t4", 32'(bclk), 32'd1);
      if (t == 8) begin
        chk("idle_bclk_t8", 32'(bclk), 32'd0);
        chk("idle_fs_t8",   32'(fs),   32'd1);
        chk("idle_ur_t8",   32'(ur),   32'd1);
      end
      if (t == 9) begin
        chk("idle_fs_t9", 32'(fs), 32'd0);
        chk("idle_ur_t9", 32'(ur), 32'd0);
      end
      if (t >= 9 && fs) begin fs_cnt++; fs_last = t; end
      if (t >= 9 && ur) ur_cnt++;
      if (dout) ones++;
    end
    chk("idle_fs_count", 32'(fs_cnt),  32'd1);
    chk("idle_ur_count", 32'(ur_cnt),  32'd1);
    chk("idle_fs_at",    32'(fs_last), 32'd520);
    chk("idle_dout",     32'(ones),    32'd0);

    // Pattern pair offered before the first load
    do_reset();
    tick();
    valid = 1'b1; dl = 24'hA5A5A5; dr = 24'h5A5A5A;
    tick();
    valid = 1'b0;
    chk("pat_ready_low", 32'(ready), 32'd0);
    wait_fs("pat", el);
    chk("pat_load_at", 32'(el),    32'd6);
    chk("pat_ur",      32'(ur),    32'd0);
    chk("pat_ready",   32'(ready), 32'd1);
    capture("pat", sl, sr, wl, wr);
    chk("pat_left",  sl, {1'b0, 24'hA5A5A5, 7'b0});
    chk("pat_right", sr, {1'b0, 24'h5A5A5A, 7'b0});
    chk("pat_wl",    wl, 32'h0000_0000);
    chk("pat_wr",    wr, 32'hFFFF_FFFF);

    // Two pairs back-to-back with valid held high
    do_reset();
    tick();
    valid = 1'b1; dl = 24'h123456; dr = 24'hABCDEF;
    tick();
    dl = 24'h654321; dr = 24'hFEDCBA;
    chk("b2b_ready_t2", 32'(ready), 32'd0);
    repeat (5) tick();
    chk("b2b_ready_t7", 32'(ready), 32'd0);
    tick();
    chk("b2b_fs_t8",    32'(fs),    32'd1);
    chk("b2b_ur_t8",    32'(ur),    32'd0);
    chk("b2b_ready_t8", 32'(ready), 32'd1);
    tick();
    valid = 1'b0;
    chk("b2b_ready_t9", 32'(ready), 32'd0);
    capture("b2b_a", sl, sr, wl, wr);
    chk("b2b_a_left",  sl, {1'b0, 24'h123456, 7'b0});
    chk("b2b_a_right", sr, {1'b0, 24'hABCDEF, 7'b0});
    wait_fs("b2b_b", el);
    chk("b2b_b_load_at", 32'(el), 32'd4);
    chk("b2b_b_ur",      32'(ur), 32'd0);
    capture("b2b_b", sl, sr, wl, wr);
    chk("b2b_b_left",  sl, {1'b0, 24'h654321, 7'b0});
    chk("b2b_b_right", sr, {1'b0, 24'hFEDCBA, 7'b0});
    wait_fs("b2b_c", el);
    chk("b2b_c_ur", 32'(ur), 32'd1);

    // Full-scale samples
    do_reset();
    tick();
    valid = 1'b1; dl = 24'h800000; dr = 24'h7FFFFF;
    tick();
    valid = 1'b0;
    wait_fs("fs", el);
    capture("fsc", sl, sr, wl, wr);
    chk("fsc_left",  sl, 32'h4000_0000);
    chk("fsc_right", sr, 32'h3FFF_FF80);

    // Reset mid-frame at bit_cnt 40 with a pair in flight and one held
    do_reset();
    tick();
    valid = 1'b1; dl = 24'h0F0F0F; dr = 24'hFFFFFF;
    tick();
    valid = 1'b0;
    wait_fs("mid", el);
    valid = 1'b1; dl = 24'h111111; dr = 24'h111111;
    tick();
    valid = 1'b0;
    chk("mid_ready_held", 32'(ready), 32'd0);
    repeat (319) tick();
    chk("mid_wclk_b40", 32'(wclk), 32'd1);
    chk("mid_dout_b40", 32'(dout), 32'd1);
    rst = 1'b1;
    tick();
    chk("mid_rst_bclk",  32'(bclk),  32'd0);
    chk("mid_rst_wclk",  32'(wclk),  32'd0);
    chk("mid_rst_dout",  32'(dout),  32'd0);
    chk("mid_rst_fs",    32'(fs),    32'd0);
    chk("mid_rst_ur",    32'(ur),    32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    rst = 1'b0;
    wait_fs("mid_post", el);
    chk("mid_post_at", 32'(el), 32'd8);
    chk("mid_post_ur", 32'(ur), 32'd1);
    capture("mid_post", sl, sr, wl, wr);
    chk("mid_post_left",  sl, 32'h0);
    chk("mid_post_right", sr, 32'h0);

    chk("dout_on_fall_only", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 24: sample width in bits, with WIDTH <= SLOT_BITS-1.
REQ-002 SHALL have parameter SLOT_BITS, default 32: bit clocks per channel slot.
REQ-003 SHALL have parameter BCLK_DIV, default 4: dac_clk cycles per bclk half-period, with BCLK_DIV >= 2.
REQ-004 SHALL have port dac_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port dac_clk_rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port dataL  in  WIDTH  left sample, two's complement.
REQ-007 SHALL have port dataR  in  WIDTH  right sample, two's complement.
REQ-008 SHALL have port valid  in  1  dataL/dataR pair offered.
REQ-009 SHALL have port ready  out  1  holding register empty; a pair is accepted when valid && ready.
REQ-010 SHALL have port i2s_bclk  out  1  generated bit clock.
REQ-011 SHALL have port i2s_wclk  out  1  word clock: 0 = left slot, 1 = right slot.
REQ-012 SHALL have port i2s_dout  out  1  serial data, Philips I2S format.
REQ-013 SHALL have port frame_start  out  1  one-cycle pulse when a frame loads.
REQ-014 SHALL have port underrun  out  1  one-cycle pulse when a frame loads with no pair available.

Function
REQ-015 SHALL generate the bit clock with a divider counter div_cnt (0..BCLK_DIV-1); when div_cnt==BCLK_DIV-1, div_cnt wraps and i2s_bclk toggles.
REQ-016 SHALL define a "fall event" as the cycle in which i2s_bclk toggles 1->0; i2s_wclk, i2s_dout, frame_start, underrun and bit_cnt change only on fall events, except that frame_start/underrun return to 0 the next cycle.
REQ-017 SHALL keep bit_cnt (0..2*SLOT_BITS-1), incremented on each fall event and wrapping 2*SLOT_BITS-1 -> 0.
REQ-018 SHALL, on the fall event where the new bit_cnt = n: set i2s_wclk = (n >= SLOT_BITS); set slot bit k = n mod SLOT_BITS; drive i2s_dout = sample[WIDTH-k] for 1 <= k <= WIDTH (MSB first, one-bclk delay after the wclk edge), else 0. The sample is the frame L for n < SLOT_BITS, else the frame R.
REQ-019 SHALL keep a holding register (L, R, hold_full); ready = ~hold_full, registered. On valid && ready, it captures dataL/dataR and sets hold_full=1 the next cycle.
REQ-020 SHALL, on the fall event where the new bit_cnt = 0 (frame load):
  - if hold_full: copy holding to frame registers, clear hold_full, pulse frame_start;
  - else: load zeros into the frame registers, pulse frame_start and underrun.
REQ-021 SHALL, when a frame load and valid coincide while hold_full=1, leave ready=0, ignore valid that cycle, and raise ready the cycle after the load.
REQ-022 SHALL ensure frame registers change only at a frame load; a new pair never corrupts a frame in flight.
REQ-023 SHALL guarantee that sample bits are stable across every bclk rising edge; i2s_dout changes only on the bclk falling edge.

Reset
REQ-024 SHALL, in the cycle after dac_clk_rst is high, set: i2s_bclk=0, i2s_wclk=0, i2s_dout=0, frame_start=0, underrun=0, ready=1, div_cnt=0, bit_cnt=2*SLOT_BITS-1, hold_full=0, frame registers=0.
REQ-025 SHALL make reset take effect immediately mid-frame, discarding held and in-flight samples; the first fall event after release is a frame load.
REQ-026 SHALL, after reset release, produce the first bclk rise BCLK_DIV cycles later and the first fall event/frame load 2*BCLK_DIV cycles later.

Verification (defaults: bclk period 8 cycles, frame 512 cycles)
REQ-027 SHALL cover: reset released, no valid -> bclk rises at cycle 4, falls at cycle 8; frame_start and underrun pulse at cycle 8 and every 512 cycles thereafter; dout stays 0.
REQ-028 SHALL cover: pair L=0xA5A5A5, R=0x5A5A5A offered before the first load -> sampled on bclk rises, the left slot reads 0 then 1010_0101_1010_0101_1010_0101 then 7 zeros with wclk=0; the right slot likewise with 0x5A5A5A and wclk=1; no underrun pulse.
REQ-029 SHALL cover: valid held high with two pairs back-to-back -> the first is accepted, ready=0 until the frame load, the second is accepted the cycle after ready returns, and it is transmitted in the following frame.
REQ-030 SHALL cover: full-scale L=0x800000, R=0x7FFFFF -> left slot bit 1 = 1 with bits 2..24 = 0; right slot bit 1 = 0 with bits 2..24 = 1.
REQ-031 SHALL cover: reset asserted at bit_cnt=40 with data in flight -> all outputs return to reset values next cycle; the first post-release frame is an underrun unless a new pair is offered.
